// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates ALU/LSU writebacks onto one register-file port
// and keeps a pending-write scoreboard that stalls decode on RAW/WAW hazards.
module wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_valid_i,
  input  logic            id_rs2_valid_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_alloc_i,
  output logic            id_stall_o,
  input  logic            ex_wb_valid_i,
  input  logic [4:0]      ex_wb_addr_i,
  input  logic [XLEN-1:0] ex_wb_data_i,
  output logic            ex_wb_ready_o,
  input  logic            lsu_wb_valid_i,
  input  logic [4:0]      lsu_wb_addr_i,
  input  logic [XLEN-1:0] lsu_wb_data_i,
  output logic            lsu_wb_ready_o,
  output logic            rf_wr_valid_o,
  output logic [4:0]      rf_wr_addr_o,
  output logic [XLEN-1:0] rf_wr_data_o,
  output logic [NREG-1:0] busy_o,
  output logic            err_o
);

  typedef enum logic {
    LAST_EX  = 1'b0,
    LAST_LSU = 1'b1
  } last_t;

  last_t           last_q, last_d;
  logic            ex_gnt, lsu_gnt, wb_fire;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [NREG-1:0] busy_q, busy_d, set_vec, clr_vec;
  logic            err_q, err_set;

  // Round-robin between the two writeback sources; nothing is granted in reset.
  always_comb begin
    ex_gnt  = !rst_n && ex_wb_valid_i  && (!lsu_wb_valid_i || last_q == LAST_LSU);
    lsu_gnt = !rst_n && lsu_wb_valid_i && (!ex_wb_valid_i  || last_q == LAST_EX);
    wb_fire = ex_gnt || lsu_gnt;
    wb_addr = lsu_gnt ? lsu_wb_addr_i : ex_wb_addr_i;
    wb_data = lsu_gnt ? lsu_wb_data_i : ex_wb_data_i;
  end

  always_comb begin
    last_d = last_q;
    if (ex_gnt)
      last_d = LAST_EX;
    else if (lsu_gnt)
      last_d = LAST_LSU;
  end

  assign ex_wb_ready_o  = ex_gnt;
  assign lsu_wb_ready_o = lsu_gnt;

  // Hazards are judged against the registered scoreboard only, with no bypass.
  assign id_stall_o = (id_rs1_valid_i && busy_q[id_rs1_addr_i]) ||
                      (id_rs2_valid_i && busy_q[id_rs2_addr_i]) ||
                      (id_rd_alloc_i  && busy_q[id_rd_addr_i]);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (id_rd_alloc_i && !id_stall_o && id_rd_addr_i != 5'd0)
      set_vec[id_rd_addr_i] = 1'b1;
    if (rf_wr_valid_o)
      clr_vec[rf_wr_addr_o] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  // A nonzero writeback with no pending allocation (now or at this edge) is an error.
  assign err_set = wb_fire && wb_addr != 5'd0 && !busy_q[wb_addr] && !set_vec[wb_addr];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rf_wr_valid_o <= 1'b0;
      rf_wr_addr_o  <= '0;
      rf_wr_data_o  <= '0;
      busy_q        <= '0;
      err_q         <= 1'b0;
      last_q        <= LAST_EX;
    end else begin
      rf_wr_valid_o <= wb_fire && wb_addr != 5'd0;
      if (wb_fire) begin
        rf_wr_addr_o <= wb_addr;
        rf_wr_data_o <= wb_data;
      end
      busy_q <= busy_d;
      err_q  <= err_q || err_set;
      last_q <= last_d;
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_wb_sched.sv
// Directed self-checking bench for wb_sched: scoreboard, stall, arbitration,
// x0 handling, sticky error and mid-operation reset.
module tb_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_rs1_valid_i, id_rs2_valid_i, id_rd_alloc_i, id_stall_o;
  logic        ex_wb_valid_i, ex_wb_ready_o;
  logic [4:0]  ex_wb_addr_i;
  logic [31:0] ex_wb_data_i;
  logic        lsu_wb_valid_i, lsu_wb_ready_o;
  logic [4:0]  lsu_wb_addr_i;
  logic [31:0] lsu_wb_data_i;
  logic        rf_wr_valid_o;
  logic [4:0]  rf_wr_addr_o;
  logic [31:0] rf_wr_data_o;
  logic [31:0] busy_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  wb_sched #(.XLEN(32), .NREG(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs1_valid_i (id_rs1_valid_i),
    .id_rs2_valid_i (id_rs2_valid_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_rd_alloc_i  (id_rd_alloc_i),
    .id_stall_o     (id_stall_o),
    .ex_wb_valid_i  (ex_wb_valid_i),
    .ex_wb_addr_i   (ex_wb_addr_i),
    .ex_wb_data_i   (ex_wb_data_i),
    .ex_wb_ready_o  (ex_wb_ready_o),
    .lsu_wb_valid_i (lsu_wb_valid_i),
    .lsu_wb_addr_i  (lsu_wb_addr_i),
    .lsu_wb_data_i  (lsu_wb_data_i),
    .lsu_wb_ready_o (lsu_wb_ready_o),
    .rf_wr_valid_o  (rf_wr_valid_o),
    .rf_wr_addr_o   (rf_wr_addr_o),
    .rf_wr_data_o   (rf_wr_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic rs1v, input logic [4:0] rs1,
                               input logic rs2v, input logic [4:0] rs2,
                               input logic alloc, input logic [4:0] rd,
                               input logic exv, input logic [4:0] exa, input logic [31:0] exd,
                               input logic lsuv, input logic [4:0] lsua, input logic [31:0] lsud);
    id_rs1_valid_i = rs1v;  id_rs1_addr_i = rs1;
    id_rs2_valid_i = rs2v;  id_rs2_addr_i = rs2;
    id_rd_alloc_i  = alloc; id_rd_addr_i  = rd;
    ex_wb_valid_i  = exv;   ex_wb_addr_i  = exa;  ex_wb_data_i  = exd;
    lsu_wb_valid_i = lsuv;  lsu_wb_addr_i = lsua; lsu_wb_data_i = lsud;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b1;
    idle();
    stepClock();
    rst_n = 1'b0;
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    stepClock();
    stepClock();
    // Requests during reset must be refused and leave no trace.
    applyStimulus(0, 0, 0, 0, 1, 5, 1, 5, 32'h1, 1, 6, 32'h2);
    checkOutput("rst_ex_ready", ex_wb_ready_o, 0);
    checkOutput("rst_lsu_ready", lsu_wb_ready_o, 0);
    stepClock();
    rst_n = 1'b0;
    idle();
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_rf_valid", rf_wr_valid_o, 0);
    checkOutput("rst_rf_addr", rf_wr_addr_o, 0);
    checkOutput("rst_rf_data", rf_wr_data_o, 0);
    checkOutput("rst_err", err_o, 0);

    // Alloc x5, RAW stall, EX writeback clears it two cycles later.
    applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_alloc_stall", id_stall_o, 0);
    stepClock();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_busy", busy_o, 32'h20);
    checkOutput("t1_raw_stall", id_stall_o, 1);
    applyStimulus(1, 5, 0, 0, 0, 0, 1, 5, 32'hABCD, 0, 0, 0);
    checkOutput("t1_ex_ready", ex_wb_ready_o, 1);
    stepClock();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_rf_valid", rf_wr_valid_o, 1);
    checkOutput("t1_rf_addr", rf_wr_addr_o, 5);
    checkOutput("t1_rf_data", rf_wr_data_o, 32'hABCD);
    checkOutput("t1_busy_held", busy_o, 32'h20);
    checkOutput("t1_no_bypass", id_stall_o, 1);
    stepClock();
    checkOutput("t1_rf_valid_off", rf_wr_valid_o, 0);
    checkOutput("t1_rf_data_hold", rf_wr_data_o, 32'hABCD);
    checkOutput("t1_busy_clr", busy_o, 0);
    checkOutput("t1_stall_drop", id_stall_o, 0);
    checkOutput("t1_err", err_o, 0);

    // First contention after reset goes to LSU, then EX.
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_busy", busy_o, 32'h18);
    checkOutput("t2_rs2_stall", id_stall_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
    checkOutput("t2_lsu_first", lsu_wb_ready_o, 1);
    checkOutput("t2_ex_wait", ex_wb_ready_o, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0);
    checkOutput("t2_ex_second", ex_wb_ready_o, 1);
    checkOutput("t2_rf1_valid", rf_wr_valid_o, 1);
    checkOutput("t2_rf1_addr", rf_wr_addr_o, 4);
    checkOutput("t2_rf1_data", rf_wr_data_o, 32'h44);
    stepClock();
    idle();
    checkOutput("t2_rf2_valid", rf_wr_valid_o, 1);
    checkOutput("t2_rf2_addr", rf_wr_addr_o, 3);
    checkOutput("t2_rf2_data", rf_wr_data_o, 32'h33);
    checkOutput("t2_busy_mid", busy_o, 32'h08);
    stepClock();
    checkOutput("t2_busy_end", busy_o, 0);

    // Both held valid: grants alternate starting with LSU (last grant was EX).
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'(i), 1, 0, 32'(i + 16));
      checkOutput("t3_lsu_ready", lsu_wb_ready_o, (i % 2 == 0) ? 1 : 0);
      checkOutput("t3_ex_ready", ex_wb_ready_o, (i % 2 == 0) ? 0 : 1);
      stepClock();
    end
    idle();
    checkOutput("t3_rf_valid", rf_wr_valid_o, 0);
    checkOutput("t3_err", err_o, 0);

    // x0 writes are silent; a write to a non-busy register latches err.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0);
    checkOutput("t4_x0_ready", ex_wb_ready_o, 1);
    stepClock();
    idle();
    checkOutput("t4_x0_rf_valid", rf_wr_valid_o, 0);
    checkOutput("t4_x0_err", err_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0);
    checkOutput("t4_x9_ready", ex_wb_ready_o, 1);
    stepClock();
    idle();
    checkOutput("t4_err_set", err_o, 1);
    checkOutput("t4_x9_rf_valid", rf_wr_valid_o, 1);
    stepClock();
    checkOutput("t4_err_sticky", err_o, 1);

    // Alloc x7 while a stray rf write clears x7: the set wins, then WAW stall.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_x7_rf_addr", rf_wr_addr_o, 7);
    checkOutput("t4_x7_alloc_ok", id_stall_o, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_set_wins", busy_o, 32'h80);
    checkOutput("t4_waw_stall", id_stall_o, 1);
    stepClock();
    idle();
    checkOutput("t4_busy_kept", busy_o, 32'h80);

    // Writeback to a register allocated at the same edge is not an error.
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 6, 1, 6, 32'h66, 0, 0, 0);
    checkOutput("t5_ex_ready", ex_wb_ready_o, 1);
    stepClock();
    idle();
    checkOutput("t5_err", err_o, 0);
    checkOutput("t5_busy", busy_o, 32'h40);

    // Mid-operation reset drops the pending write and re-arms LSU priority.
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44);
    checkOutput("t6_lsu_ready", lsu_wb_ready_o, 1);
    stepClock();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h9);
    checkOutput("t6_pre_busy", busy_o, 32'h30);
    checkOutput("t6_pre_rf_valid", rf_wr_valid_o, 1);
    checkOutput("t6_rst_lsu_ready", lsu_wb_ready_o, 0);
    stepClock();
    rst_n = 1'b0;
    idle();
    checkOutput("t6_busy", busy_o, 0);
    checkOutput("t6_rf_valid", rf_wr_valid_o, 0);
    checkOutput("t6_rf_addr", rf_wr_addr_o, 0);
    checkOutput("t6_rf_data", rf_wr_data_o, 0);
    checkOutput("t6_err", err_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 32'h1, 1, 0, 32'h2);
    checkOutput("t6_lsu_wins", lsu_wb_ready_o, 1);
    checkOutput("t6_ex_loses", ex_wb_ready_o, 0);
    stepClock();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 Parameter XLEN, default 32: width of writeback data.
REQ-002 Parameter NREG, default 32: number of architectural registers; addresses are 5 bits.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, synchronous and active-high: asserted when 1, sampled on clk rising edge.
REQ-005 Ports id_rs1_addr_i and id_rs2_addr_i  in  5  source register addresses from decode.
REQ-006 Ports id_rs1_valid_i and id_rs2_valid_i  in  1  the corresponding source operand is read this cycle.
REQ-007 Port id_rd_addr_i  in  5  destination register of the instruction in decode.
REQ-008 Port id_rd_alloc_i  in  1  the instruction in decode will write id_rd_addr_i.
REQ-009 Port id_stall_o  out  1  decode must hold; no issue this cycle.
REQ-010 Ports ex_wb_valid_i, ex_wb_addr_i[4:0], ex_wb_data_i[XLEN-1:0]  in  ALU writeback request.
REQ-011 Port ex_wb_ready_o  out  1  ALU request accepted this cycle.
REQ-012 Ports lsu_wb_valid_i, lsu_wb_addr_i[4:0], lsu_wb_data_i[XLEN-1:0]  in  load writeback request.
REQ-013 Port lsu_wb_ready_o  out  1  load request accepted this cycle.
REQ-014 Ports rf_wr_valid_o, rf_wr_addr_o[4:0], rf_wr_data_o[XLEN-1:0]  out  registered write port to the register file.
REQ-015 Port busy_o  out  NREG  scoreboard; bit n set means register n has a pending write.
REQ-016 Port err_o  out  1  sticky error: a writeback targeted a register that was not busy.

Function
REQ-017 Arbitration is combinational; each requester's ready output equals its grant in the same cycle.
REQ-018 Grant rules: if only one requester is valid, it is granted. If both are valid, the requester not granted most recently is granted. Last-grant resets to EX, so LSU wins the first contention.
REQ-019 A requester holds valid, address and data stable until ready; the block never grants a request that is not valid.
REQ-020 A grant loads rf_wr_addr_o and rf_wr_data_o at the next edge. rf_wr_valid_o is set at that edge for nonzero addresses and cleared otherwise, giving one cycle of latency.
REQ-021 With no grant, rf_wr_valid_o returns to 0 at the next edge. rf_wr_addr_o and rf_wr_data_o hold their values.
REQ-022 Writebacks to x0 are accepted (ready = 1), produce no rf write, and do not set err_o.
REQ-023 Busy bit set: at the edge where id_rd_alloc_i = 1, id_stall_o = 0 and id_rd_addr_i != 0, busy[id_rd_addr_i] is set.
REQ-024 Busy bit clear: at the edge ending a cycle with rf_wr_valid_o = 1, busy[rf_wr_addr_o] is cleared.
REQ-025 If a set and a clear target the same register at the same edge, set wins.
REQ-026 busy[0] is always 0.
REQ-027 id_stall_o is combinational. It is 1 when any of the following holds: (id_rs1_valid_i & busy[id_rs1_addr_i]), (id_rs2_valid_i & busy[id_rs2_addr_i]), or (id_rd_alloc_i & busy[id_rd_addr_i]) (WAW).
REQ-028 Stall evaluation uses the current busy state only; there is no bypass from rf_wr_* in the same cycle.
REQ-029 err_o is set at the edge of a grant whose nonzero address is not busy and is not being set at that same edge. It stays 1 until reset.

Reset
REQ-030 While rst_n = 1 at an edge, the following are cleared: rf_wr_valid_o, rf_wr_addr_o, rf_wr_data_o, busy_o and err_o; last-grant is forced to EX.
REQ-031 Requests presented while rst_n = 1 are discarded without side effects. Ready outputs are 0 during reset and resume normal behaviour on the first edge after rst_n deasserts.
REQ-032 Asserting reset mid-operation drops any pending rf write and clears all busy bits with no partial update.

Verification
REQ-033 Alloc x5 -> busy_o = 0x20. Then rs1 = x5 valid -> id_stall_o = 1. EX writes x5 = 0xABCD -> ready in the same cycle, rf_wr_valid_o = 1 next cycle with addr 5 and data 0xABCD, busy_o = 0 one cycle later, stall drops.
REQ-034 x3 and x4 busy; EX (x3) and LSU (x4) valid in the same cycle from reset -> LSU granted first, EX next cycle. rf writes are x4 then x3 in consecutive cycles.
REQ-035 LSU held valid continuously while EX valid for 3 cycles -> grants alternate LSU, EX, LSU, EX.
REQ-036 Alloc x7 in the same cycle that rf_wr clears x7 -> busy[7] remains 1. A second alloc of x7 -> id_stall_o = 1 (WAW).
REQ-037 EX writes x0 -> ready = 1, rf_wr_valid_o stays 0, err_o stays 0. EX writes non-busy x9 -> err_o = 1 and stays 1 until reset.
REQ-038 Assert rst_n = 1 for one edge with busy_o = 0x30 and rf_wr_valid_o = 1 -> all outputs are 0 next cycle, and the next contention grants LSU.
